// File: rtl/onehot_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec_pkg
//  Description : Shared definitions for the 3-to-8 one-hot pulse decoder:
//                FSM state encoding, code/one-hot widths, default pulse
//                length and the decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package onehot_dec_pkg;

    localparam int unsigned c_code_w            = 3;
    localparam int unsigned c_oh_w              = 8;
    localparam int unsigned c_cnt_w             = 8;
    localparam int unsigned c_pulse_len_default = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Binary index to one-hot; exactly one bit is ever set.
    function automatic logic [c_oh_w-1:0] decode_oh(input logic [c_code_w-1:0] code);
        logic [c_oh_w-1:0] oh;
        oh = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage : onehot_dec_pkg
`default_nettype wire

// File: rtl/onehot_dec_timer.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec_timer
//  Description : Pulse hold counter. Loads PULSE_LEN-1 on load, counts down
//                to zero and stops there (never underflows). clear has
//                priority and forces the count to zero.
//  Ports       : clk    - clock (rising edge)
//                rst_n  - asynchronous active-low reset
//                load   - reload with PULSE_LEN-1
//                clear  - synchronous clear to zero
//                zero   - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec_timer
    import onehot_dec_pkg::*;
#(
    parameter int unsigned PULSE_LEN = c_pulse_len_default
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic zero
);

    localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(PULSE_LEN - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule : onehot_dec_timer
`default_nettype wire

// File: rtl/onehot_decoder_3_to_8.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_decoder_3_to_8
//  Description : Accepts a 3-bit code with valid/ready handshake and drives
//                the registered one-hot decode for PULSE_LEN cycles. A new
//                code may be accepted on the last cycle of a pulse so that
//                consecutive pulses abut with no gap. flush aborts a pulse
//                and blocks acceptance in the same cycle.
//  Build option: ONEHOT_DEC_STICKY_EN adds sticky_clr/sticky, an 8-bit
//                record of every code accepted since the last clear.
//  Ports       : clk, rst_n (async active-low), in_code[2:0], in_valid,
//                in_ready, flush, out_oh[7:0], out_valid, busy
//                [sticky_clr, sticky[7:0] with ONEHOT_DEC_STICKY_EN]
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder_3_to_8
    import onehot_dec_pkg::*;
#(
    parameter int unsigned PULSE_LEN = c_pulse_len_default
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [c_code_w-1:0] in_code,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [c_oh_w-1:0]   out_oh,
    output logic                out_valid,
    output logic                busy
`ifdef ONEHOT_DEC_STICKY_EN
    ,
    input  logic                sticky_clr,
    output logic [c_oh_w-1:0]   sticky
`endif
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_oh_w-1:0]   r_out_oh;
    logic [c_oh_w-1:0]   w_out_oh_nxt;
    logic                w_cnt_zero;
    logic                w_accept;

    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign w_accept = in_valid && in_ready;

    onehot_dec_timer #(
        .PULSE_LEN (PULSE_LEN)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .clear (flush),
        .zero  (w_cnt_zero)
    );

    // State and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_out_oh <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_out_oh <= w_out_oh_nxt;
        end
    end

    // Next-state logic; flush wins over everything, an accept on the last
    // pulse cycle reloads directly without passing through IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_out_oh_nxt = r_out_oh;
        if (flush) begin
            w_state_nxt  = IDLE;
            w_out_oh_nxt = '0;
        end else if (w_accept) begin
            w_state_nxt  = ACTIVE;
            w_out_oh_nxt = decode_oh(in_code);
        end else if (r_state == ACTIVE && w_cnt_zero) begin
            w_state_nxt  = IDLE;
            w_out_oh_nxt = '0;
        end
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (rst_n && !flush) begin
            in_ready = (r_state == IDLE) || w_cnt_zero;
        end
        out_valid = (r_state == ACTIVE);
        busy      = (r_state == ACTIVE);
    end

    assign out_oh = r_out_oh;

`ifdef ONEHOT_DEC_STICKY_EN
    logic [c_oh_w-1:0] r_sticky;

    // A clear coinciding with an accept leaves only the new code's bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (w_accept) begin
            r_sticky <= (sticky_clr ? '0 : r_sticky) | decode_oh(in_code);
        end else if (sticky_clr) begin
            r_sticky <= '0;
        end
    end

    assign sticky = r_sticky;
`endif

endmodule : onehot_decoder_3_to_8
`default_nettype wire

// File: tb/tb_onehot_decoder_3_to_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_decoder_3_to_8
//  Description : Self-checking bench. Two instances (PULSE_LEN 4 and 1) share
//                one stimulus stream; each is compared every cycle against a
//                pulse-lifetime reference model, plus directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_decoder_3_to_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_code;
    logic       in_valid;
    logic       flush;
    logic       sticky_clr;

    logic       rdy4, ov4, busy4, rdy1, ov1, busy1;
    logic [7:0] oh4, oh1;
`ifdef ONEHOT_DEC_STICKY_EN
    logic [7:0] st4, st1;
`endif

    always #5 clk = ~clk;

    onehot_decoder_3_to_8 #(.PULSE_LEN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(rdy4), .flush(flush), .out_oh(oh4), .out_valid(ov4), .busy(busy4)
`ifdef ONEHOT_DEC_STICKY_EN
        , .sticky_clr(sticky_clr), .sticky(st4)
`endif
    );

    onehot_decoder_3_to_8 #(.PULSE_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(rdy1), .flush(flush), .out_oh(oh1), .out_valid(ov1), .busy(busy1)
`ifdef ONEHOT_DEC_STICKY_EN
        , .sticky_clr(sticky_clr), .sticky(st1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles of pulse life remaining, displayed code, sticky.
    int         pl   [2] = '{4, 1};
    int         rem  [2];
    logic [7:0] m_oh [2];
    logic [7:0] m_st [2];
    logic       acc  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready(input int k);
        return rst_n && !flush && (rem[k] <= 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; m_oh[k] = 8'h00; m_st[k] = 8'h00;
        end
    endtask

    task automatic check_outputs();
        check("oh4",    {24'd0, oh4}, {24'd0, m_oh[0]});
        check("valid4", {31'd0, ov4}, {31'd0, rem[0] > 0});
        check("busy4",  {31'd0, busy4}, {31'd0, rem[0] > 0});
        check("oh1",    {24'd0, oh1}, {24'd0, m_oh[1]});
        check("valid1", {31'd0, ov1}, {31'd0, rem[1] > 0});
        check("busy1",  {31'd0, busy1}, {31'd0, rem[1] > 0});
`ifdef ONEHOT_DEC_STICKY_EN
        check("sticky4", {24'd0, st4}, {24'd0, m_st[0]});
        check("sticky1", {24'd0, st1}, {24'd0, m_st[1]});
`endif
    endtask

    // One clock cycle: drive at negedge, check ready, advance model at the
    // edge, check registered outputs just after it.
    task automatic step(input logic v, input logic [2:0] c, input logic f, input logic clr);
        logic [7:0] bitv;
        @(negedge clk);
        in_valid = v; in_code = c; flush = f; sticky_clr = clr;
        #1;
        check("ready4", {31'd0, rdy4}, {31'd0, exp_ready(0)});
        check("ready1", {31'd0, rdy1}, {31'd0, exp_ready(1)});
        for (int k = 0; k < 2; k++) acc[k] = v && exp_ready(k);
        @(posedge clk);
        bitv = 8'd1 << c;
        for (int k = 0; k < 2; k++) begin
            if (f) begin
                rem[k] = 0; m_oh[k] = 8'h00;
            end else if (acc[k]) begin
                rem[k] = pl[k]; m_oh[k] = bitv;
            end else if (rem[k] > 0) begin
                rem[k]--;
                if (rem[k] == 0) m_oh[k] = 8'h00;
            end
            if (acc[k])   m_st[k] = (clr ? 8'h00 : m_st[k]) | bitv;
            else if (clr) m_st[k] = 8'h00;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    int hits;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_code = 3'd0; flush = 1'b0; sticky_clr = 1'b0;
        model_reset();
        #1;
        check("rst_ready4", {31'd0, rdy4}, 32'd0);
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single code 5, PULSE_LEN 4: 8'h20 for exactly 4 cycles.
        step(1'b1, 3'd5, 1'b0, 1'b0);
        hits = (oh4 == 8'h20) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
            if (oh4 == 8'h20) hits++;
        end
        check("pulse5_len", hits, 32'd4);
        check("pulse5_end", {24'd0, oh4}, 32'h00);

        // Codes 2 then 7 held valid: abutting pulses, ready only on last cycle.
        for (int i = 0; i < 4; i++) step(1'b1, 3'd2, 1'b0, 1'b0);
        check("b2b_first", {24'd0, oh4}, 32'h04);
        step(1'b1, 3'd7, 1'b0, 1'b0);
        check("b2b_second", {24'd0, oh4}, 32'h80);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd7, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        idle(4);

        // PULSE_LEN 1 walk of codes 0..7.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 1'b0, 1'b0);
            check("walk1", {24'd0, oh1}, 32'd1 << i);
        end
        idle(5);

        // Flush on cycle 2 of a code-3 pulse while code 6 is offered.
        step(1'b1, 3'd3, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd6, 1'b1, 1'b0);
        check("flush_oh4", {24'd0, oh4}, 32'h00);
        idle(3);
        check("flush_no6", {24'd0, oh4}, 32'h00);

        // Asynchronous reset mid-pulse, then an immediate accept.
        step(1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_oh4",    {24'd0, oh4}, 32'h00);
        check("arst_valid4", {31'd0, ov4}, 32'd0);
        check("arst_busy4",  {31'd0, busy4}, 32'd0);
        check("arst_ready4", {31'd0, rdy4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd2, 1'b0, 1'b0);
        check("post_rst_oh4", {24'd0, oh4}, 32'h04);
        idle(5);

`ifdef ONEHOT_DEC_STICKY_EN
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 3'd1, 1'b0, 1'b0); idle(4);
        step(1'b1, 3'd4, 1'b0, 1'b0); idle(4);
        step(1'b1, 3'd4, 1'b0, 1'b0); idle(4);
        check("sticky_acc", {24'd0, st4}, 32'h12);
        step(1'b1, 3'd0, 1'b0, 1'b1);
        check("sticky_clr", {24'd0, st4}, 32'h01);
        idle(5);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom_range(0, 3) != 0)), 3'($urandom_range(0, 7)),
                 1'(($urandom_range(0, 11) == 0)), 1'(($urandom_range(0, 9) == 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_onehot_decoder_3_to_8
`default_nettype wire
